// File: rtl/intra_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : intra_core_arbiter
// Purpose : Per-4x4-block arbiter sharing the transform/quantise core between
//           the intra4x4 luma and intra8x8 chroma datapaths.
// Revision: 1.0 - initial release
// ============================================================================
module intra_core_arbiter #(
    parameter int ROWS_PER_BLK = 4,
    parameter int FB_PER_BLK   = 16,
    parameter bit LUMA_FIRST   = 1'b1
) (
    input  logic        CLK2,
    input  logic        RESET,
    input  logic        L_REQ,
    input  logic        L_STROBE,
    input  logic [35:0] L_DATA,
    input  logic [31:0] L_BASE,
    output logic        L_GNT,
    output logic        L_READY,
    output logic        L_FBSTROBE,
    input  logic        C_REQ,
    input  logic        C_STROBE,
    input  logic [35:0] C_DATA,
    input  logic [31:0] C_BASE,
    output logic        C_GNT,
    output logic        C_READY,
    output logic        C_FBSTROBE,
    input  logic        CORE_READY,
    input  logic        CORE_FBSTROBE,
    output logic        CORE_STROBE,
    output logic [35:0] CORE_DATA,
    output logic [31:0] CORE_BASE,
    output logic        CORE_SRC,
    output logic        BUSY,
    output logic        PROTO_ERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FBWAIT = 2'd2
    } state_t;

    localparam logic [3:0] c_rows_term = 4'(ROWS_PER_BLK);
    localparam logic [5:0] c_fb_term   = 6'(FB_PER_BLK);

    state_t      r_state, w_state_nxt;
    logic        r_owner, r_luma_pri, r_l_gnt, r_c_gnt, r_busy, r_proto_err;
    logic        r_core_strobe;
    logic [35:0] r_core_data;
    logic [31:0] r_core_base;
    logic [3:0]  r_rowcnt;
    logic [5:0]  r_fbcnt;

    logic        w_rows_done, w_fb_done, w_rows_done_nxt, w_fb_done_nxt;
    logic        w_own_strobe, w_oth_strobe, w_ready, w_accept, w_fb_hit;
    logic        w_grant, w_grant_src, w_owner_nxt, w_err;
    logic [35:0] w_row_data;
    logic [31:0] w_row_base;

    always_comb begin
        w_rows_done     = (r_rowcnt == c_rows_term);
        w_fb_done       = (r_fbcnt == c_fb_term);
        w_own_strobe    = r_owner ? C_STROBE : L_STROBE;
        w_oth_strobe    = r_owner ? L_STROBE : C_STROBE;
        w_row_data      = r_owner ? C_DATA : L_DATA;
        w_row_base      = r_owner ? C_BASE : L_BASE;
        w_ready         = ~RESET & (r_state == STREAM) & CORE_READY & ~w_rows_done;
        w_accept        = w_own_strobe & w_ready;
        w_fb_hit        = ~RESET & CORE_FBSTROBE & (r_state != IDLE);
        // Completion includes this cycle's event so release happens at the edge
        // that consumes the last row/feedback, even when both coincide.
        w_rows_done_nxt = w_rows_done | (w_accept & (r_rowcnt == c_rows_term - 4'd1));
        w_fb_done_nxt   = w_fb_done | (w_fb_hit & (r_fbcnt == c_fb_term - 6'd1));

        w_grant     = 1'b0;
        w_grant_src = 1'b0;
        w_err       = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                w_err = L_STROBE | C_STROBE | CORE_FBSTROBE;
                if (L_REQ | C_REQ) begin
                    w_grant     = 1'b1;
                    w_grant_src = (L_REQ & C_REQ) ? ~r_luma_pri : C_REQ;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                w_err = w_oth_strobe | (w_own_strobe & ~w_ready)
                      | (w_fb_done_nxt & ~w_rows_done_nxt);
                if (w_rows_done_nxt & w_fb_done_nxt) begin
                    w_state_nxt = IDLE;
                end else if (w_rows_done_nxt) begin
                    w_state_nxt = FBWAIT;
                end
            end
            FBWAIT: begin
                w_err = L_STROBE | C_STROBE;
                if (w_fb_done_nxt) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_owner_nxt = w_grant ? w_grant_src : r_owner;
    end

    always_ff @(posedge CLK2) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_luma_pri    <= LUMA_FIRST;
            r_l_gnt       <= 1'b0;
            r_c_gnt       <= 1'b0;
            r_busy        <= 1'b0;
            r_proto_err   <= 1'b0;
            r_core_strobe <= 1'b0;
            r_core_data   <= '0;
            r_core_base   <= '0;
            r_rowcnt      <= '0;
            r_fbcnt       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_busy        <= (w_state_nxt != IDLE);
            r_l_gnt       <= (w_state_nxt != IDLE) & ~w_owner_nxt;
            r_c_gnt       <= (w_state_nxt != IDLE) & w_owner_nxt;
            r_core_strobe <= w_accept;
            if (w_accept) begin
                r_core_data <= w_row_data;
                r_core_base <= w_row_base;
            end
            if (w_grant) begin
                r_rowcnt <= '0;
                r_fbcnt  <= '0;
            end else begin
                if (w_accept) begin
                    r_rowcnt <= r_rowcnt + 4'd1;
                end
                if (w_fb_hit & ~w_fb_done) begin
                    r_fbcnt <= r_fbcnt + 6'd1;
                end
            end
            // Owner of the block just finished gets lowest priority on the next tie.
            if ((r_state != IDLE) && (w_state_nxt == IDLE)) begin
                r_luma_pri <= r_owner;
            end
            if (w_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign L_GNT       = r_l_gnt;
    assign C_GNT       = r_c_gnt;
    assign L_READY     = w_ready & ~r_owner;
    assign C_READY     = w_ready & r_owner;
    assign L_FBSTROBE  = w_fb_hit & ~r_owner;
    assign C_FBSTROBE  = w_fb_hit & r_owner;
    assign CORE_STROBE = r_core_strobe;
    assign CORE_DATA   = r_core_data;
    assign CORE_BASE   = r_core_base;
    assign CORE_SRC    = r_owner;
    assign BUSY        = r_busy;
    assign PROTO_ERR   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_intra_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_intra_core_arbiter
// Purpose : Directed self-checking bench for intra_core_arbiter with a row
//           scoreboard and feedback-pulse accounting.
// Revision: 1.0 - initial release
// ============================================================================
module tb_intra_core_arbiter;

    localparam int ROWS = 4;

    logic        CLK2, RESET;
    logic        L_REQ, L_STROBE, L_GNT, L_READY, L_FBSTROBE;
    logic [35:0] L_DATA;
    logic [31:0] L_BASE;
    logic        C_REQ, C_STROBE, C_GNT, C_READY, C_FBSTROBE;
    logic [35:0] C_DATA;
    logic [31:0] C_BASE;
    logic        CORE_READY, CORE_FBSTROBE, CORE_STROBE, CORE_SRC, BUSY, PROTO_ERR;
    logic [35:0] CORE_DATA;
    logic [31:0] CORE_BASE;

    int          n_checks = 0;
    int          n_errors = 0;
    int          l_fb_seen = 0, c_fb_seen = 0;
    int          exp_l_fb = 0, exp_c_fb = 0;
    logic [67:0] sb[$];
    logic [67:0] mon_exp;

    intra_core_arbiter #(
        .ROWS_PER_BLK(4),
        .FB_PER_BLK  (16),
        .LUMA_FIRST  (1'b1)
    ) dut (
        .CLK2         (CLK2),
        .RESET        (RESET),
        .L_REQ        (L_REQ),
        .L_STROBE     (L_STROBE),
        .L_DATA       (L_DATA),
        .L_BASE       (L_BASE),
        .L_GNT        (L_GNT),
        .L_READY      (L_READY),
        .L_FBSTROBE   (L_FBSTROBE),
        .C_REQ        (C_REQ),
        .C_STROBE     (C_STROBE),
        .C_DATA       (C_DATA),
        .C_BASE       (C_BASE),
        .C_GNT        (C_GNT),
        .C_READY      (C_READY),
        .C_FBSTROBE   (C_FBSTROBE),
        .CORE_READY   (CORE_READY),
        .CORE_FBSTROBE(CORE_FBSTROBE),
        .CORE_STROBE  (CORE_STROBE),
        .CORE_DATA    (CORE_DATA),
        .CORE_BASE    (CORE_BASE),
        .CORE_SRC     (CORE_SRC),
        .BUSY         (BUSY),
        .PROTO_ERR    (PROTO_ERR)
    );

    initial CLK2 = 1'b0;
    always #5 CLK2 = ~CLK2;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK2);
        #1;
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // Rows leaving the core port are matched in order against the scoreboard.
    always @(negedge CLK2) begin
        if (CORE_STROBE === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_core_strobe", 80'(CORE_STROBE), 80'(0));
            end else begin
                mon_exp = sb.pop_front();
                check("core_row", 80'({CORE_DATA, CORE_BASE}), 80'(mon_exp));
            end
        end
        if (L_FBSTROBE === 1'b1) l_fb_seen++;
        if (C_FBSTROBE === 1'b1) c_fb_seen++;
    end

    // mode 0: 4 back-to-back rows then 16 feedback; mode 1: 3-cycle core stall
    // after row 2; mode 2: feedback from row 2 on, last feedback with row 4.
    task automatic do_block(input bit src, input int mode, input int blk, input bit inject);
        int          n_cyc;
        int          rows;
        bit          stb, fb, crdy, exp_rdy;
        logic [35:0] d;
        logic [31:0] b;
        n_cyc = (mode == 0) ? 20 : (mode == 1) ? 23 : 18;
        rows  = 0;
        check("grant_owner", 80'({C_GNT, L_GNT, CORE_SRC, BUSY}),
              80'(src ? 4'b1011 : 4'b0101));
        for (int t = 0; t < n_cyc; t++) begin
            case (mode)
                0: begin stb = (t < 4); crdy = 1'b1; fb = (t >= 4); end
                1: begin
                    stb  = (t < 2) || (t == 5) || (t == 6);
                    crdy = !((t >= 2) && (t <= 4));
                    fb   = (t >= 7);
                end
                default: begin stb = (t < 2) || (t == 10) || (t == 17); crdy = 1'b1; fb = (t >= 2); end
            endcase
            d = 36'(blk * 16 + rows + 1);
            b = 32'hB000_0000 | 32'(blk * 256 + rows);
            CORE_READY    = crdy;
            CORE_FBSTROBE = fb;
            if (src) begin
                C_DATA = d;  C_BASE = b;  L_DATA = ~d; L_BASE = ~b;
            end else begin
                L_DATA = d;  L_BASE = b;  C_DATA = ~d; C_BASE = ~b;
            end
            L_STROBE = stb & !src;
            C_STROBE = stb & src;
            if (inject && t == 1) begin
                if (src) L_STROBE = 1'b1;
                else     C_STROBE = 1'b1;
            end
            #1;
            exp_rdy = crdy && (rows < ROWS);
            check("ready", 80'({L_READY, C_READY}), 80'(src ? {1'b0, exp_rdy} : {exp_rdy, 1'b0}));
            check("gnt_hold", 80'({C_GNT, L_GNT}), 80'(src ? 2'b10 : 2'b01));
            if (stb) sb.push_back({d, b});
            if (fb) begin
                if (src) exp_c_fb++;
                else     exp_l_fb++;
            end
            tick();
            check("core_strobe", 80'(CORE_STROBE), 80'(stb));
            if (stb) rows++;
        end
        L_STROBE = 1'b0; C_STROBE = 1'b0; CORE_FBSTROBE = 1'b0; CORE_READY = 1'b1;
        check("release", 80'({C_GNT, L_GNT, BUSY, PROTO_ERR}), 80'({3'b000, inject}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        L_REQ = 1'b0; L_STROBE = 1'b0; L_DATA = '0; L_BASE = '0;
        C_REQ = 1'b0; C_STROBE = 1'b0; C_DATA = '0; C_BASE = '0;
        CORE_READY = 1'b1; CORE_FBSTROBE = 1'b0;
        tick();
        tick();
        check("reset_outs", 80'({L_GNT, C_GNT, CORE_STROBE, CORE_DATA, CORE_BASE,
                                 CORE_SRC, BUSY, PROTO_ERR}), 80'(0));
        RESET = 1'b0;

        // Single luma block
        L_REQ = 1'b1;
        #1;
        check("idle_no_gnt", 80'({L_GNT, C_GNT, BUSY}), 80'(0));
        tick();
        L_REQ = 1'b0;
        do_block(1'b0, 0, 0, 1'b0);

        // Contention: luma, chroma, luma with one idle cycle between blocks
        pulse_reset();
        L_REQ = 1'b1; C_REQ = 1'b1;
        tick();
        do_block(1'b0, 0, 1, 1'b0);
        tick();
        do_block(1'b1, 0, 2, 1'b0);
        tick();
        do_block(1'b0, 0, 3, 1'b0);
        L_REQ = 1'b0; C_REQ = 1'b0;

        // Backpressure
        L_REQ = 1'b1;
        tick();
        L_REQ = 1'b0;
        do_block(1'b0, 1, 4, 1'b0);

        // Overlapped feedback, straight STREAM -> IDLE
        C_REQ = 1'b1;
        tick();
        C_REQ = 1'b0;
        do_block(1'b1, 2, 5, 1'b0);

        // Violations: feedback while idle, then non-owner strobe
        tick();
        CORE_FBSTROBE = 1'b1;
        #1;
        check("idle_fb_routed", 80'({L_FBSTROBE, C_FBSTROBE}), 80'(0));
        tick();
        CORE_FBSTROBE = 1'b0;
        check("idle_fb_err", 80'({PROTO_ERR, BUSY, CORE_STROBE}), 80'(3'b100));
        repeat (3) tick();
        check("err_sticky", 80'(PROTO_ERR), 80'(1));
        pulse_reset();
        check("err_cleared", 80'(PROTO_ERR), 80'(0));
        L_REQ = 1'b1;
        tick();
        L_REQ = 1'b0;
        do_block(1'b0, 0, 6, 1'b1);

        // Reset mid-block; the last completed owner was luma
        L_REQ = 1'b1;
        tick();
        L_REQ = 1'b0;
        for (int t = 0; t < 2; t++) begin
            L_STROBE = 1'b1;
            L_DATA   = 36'(7 * 16 + t + 1);
            L_BASE   = 32'hB000_0000 | 32'(7 * 256 + t);
            C_DATA   = ~L_DATA;
            C_BASE   = ~L_BASE;
            CORE_FBSTROBE = (t == 1);
            sb.push_back({L_DATA, L_BASE});
            if (t == 1) exp_l_fb++;
            tick();
        end
        L_STROBE = 1'b0;
        RESET = 1'b1;
        CORE_FBSTROBE = 1'b1;
        CORE_READY = 1'b1;
        #1;
        check("reset_comb", 80'({L_READY, C_READY, L_FBSTROBE, C_FBSTROBE}), 80'(0));
        tick();
        CORE_FBSTROBE = 1'b0;
        check("reset_mid_outs", 80'({L_GNT, C_GNT, CORE_STROBE, CORE_DATA, CORE_BASE,
                                     CORE_SRC, BUSY, PROTO_ERR}), 80'(0));
        RESET = 1'b0;
        L_REQ = 1'b1; C_REQ = 1'b1;
        tick();
        check("post_reset_tie", 80'({C_GNT, L_GNT, CORE_SRC}), 80'(3'b010));
        L_REQ = 1'b0; C_REQ = 1'b0;
        tick();

        check("sb_drained", 80'(sb.size()), 80'(0));
        check("l_fb_pulses", 80'(l_fb_seen), 80'(exp_l_fb));
        check("c_fb_pulses", 80'(c_fb_seen), 80'(exp_c_fb));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intra_core_arbiter.md
Name: intra_core_arbiter

Overview:
- Shares the single transform/quantise core between the intra4x4 luma datapath and the intra8x8 chroma datapath.
- Arbitrates per 4x4 block:
  - grants one requester;
  - forwards its residual rows (36-bit DATA plus 32-bit BASE) to the core;
  - routes the core's reconstruction feedback strobes back to that requester;
  - releases the grant once the block's feedback is complete.
- Sits between the two intra datapaths and the core input and feedback ports.
- Chroma DC strobes bypass this block.

Parameters:
ROWS_PER_BLK, 4, residual row strobes per 4x4 block (range 1..15)
FB_PER_BLK, 16, core feedback strobes per 4x4 block (range 1..63)
LUMA_FIRST, 1, round-robin pointer after reset: 1 = luma wins the first tie, 0 = chroma wins

Ports:
CLK2  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
L_REQ  in  1  luma has a 4x4 block ready; held until L_GNT
L_STROBE  in  1  luma row valid; legal only while L_READY=1
L_DATA  in  36  luma residual row {d3,d2,d1,d0}, each 9-bit signed
L_BASE  in  32  luma prediction row
L_GNT  out  1  luma owns the core
L_READY  out  1  luma may strobe a row this cycle
L_FBSTROBE  out  1  core feedback byte belongs to luma
C_REQ, C_STROBE, C_DATA, C_BASE, C_GNT, C_READY, C_FBSTROBE  same directions, widths and meanings for chroma
CORE_READY  in  1  core accepts a row next cycle
CORE_FBSTROBE  in  1  core presents a reconstructed byte on the shared FEEDBI bus
CORE_STROBE  out  1  row valid to core
CORE_DATA  out  36  row residual
CORE_BASE  out  32  row prediction
CORE_SRC  out  1  owner of the current block: 0 = luma, 1 = chroma
BUSY  out  1  state != IDLE
PROTO_ERR  out  1  sticky protocol-violation flag

Behaviour:
- Reset:
  - State = IDLE; rowcnt, fbcnt = 0; pointer = LUMA_FIRST.
  - All registered outputs are 0: L/C_GNT, CORE_STROBE, CORE_DATA, CORE_BASE, CORE_SRC, BUSY, PROTO_ERR.
  - While RESET=1, L/C_READY and L/C_FBSTROBE are forced to 0.
  - Reset mid-block aborts the block. Nothing is flushed, and the core is not notified.
- States: IDLE, STREAM, FBWAIT.
- IDLE:
  - REQ is sampled each cycle.
  - Only one REQ high: grant it.
  - Both high: grant the source that did not own the previous block (round-robin). Before any block, LUMA_FIRST decides.
  - On grant: GNT, CORE_SRC and BUSY go high at the next edge; state -> STREAM; rowcnt and fbcnt cleared.
  - A REQ that drops before being granted is simply not granted.
- STREAM:
  - Owner READY = CORE_READY & ~rows_done (combinational). The non-owner's READY = 0.
  - An owner strobe with READY=1 is accepted. It is registered to CORE_STROBE, CORE_DATA and CORE_BASE with a 1-cycle latency and rowcnt increments.
  - On the ROWS_PER_BLK-th accepted row, rows_done is set.
  - CORE_STROBE is 0 on any cycle without an accepted row. CORE_DATA and CORE_BASE hold their last values.
- Feedback counting (STREAM and FBWAIT):
  - Each CORE_FBSTROBE drives the owner's FBSTROBE in the same cycle (combinational; FEEDBI is read directly by the requesters) and increments fbcnt.
  - fb_done is set at FB_PER_BLK strobes.
- Transitions:
  - STREAM -> FBWAIT when rows_done & ~fb_done.
  - STREAM or FBWAIT -> IDLE when rows_done & fb_done, including when both complete in the same cycle.
  - On entry to IDLE, GNT drops at that edge and the pointer records the owner.
  - The earliest regrant is one cycle after returning to IDLE, giving a mandatory 1-cycle bubble.
- Protocol errors: each of the following sets PROTO_ERR (sticky until RESET):
  - A strobe from the non-owner, or any strobe in IDLE or FBWAIT. The strobe is dropped and not forwarded.
  - An owner strobe while READY=0. The strobe is dropped.
  - CORE_FBSTROBE in IDLE. The strobe is dropped and no FBSTROBE is driven.
  - fb_done reached before rows_done. The state still waits for rows_done.
- Counter widths: rowcnt 4 bits, fbcnt 6 bits. Neither wraps; both saturate at their terminal value until the block is released.

Test Plan:
- Single luma block:
  - Stimulus: L_REQ at cycle 0; CORE_READY=1; 4 strobes DATA=0x000000001..0x000000004; then 16 CORE_FBSTROBE.
  - Required: L_GNT=1 from cycle 1; CORE_STROBE on 4 consecutive cycles, each 1 cycle after its strobe, CORE_SRC=0; L_FBSTROBE=16 pulses; L_GNT=0 after the 16th; BUSY=0; PROTO_ERR=0.
- Contention round-robin:
  - Stimulus: L_REQ and C_REQ both held for 3 blocks.
  - Required: grant order luma, chroma, luma (LUMA_FIRST=1); exactly 1 idle cycle between blocks; the non-owner's READY stays 0 throughout.
- Backpressure:
  - Stimulus: CORE_READY low for 3 cycles after the 2nd row.
  - Required: owner READY=0 during those cycles; exactly 4 CORE_STROBE pulses total, in order; no data loss or duplication.
- Overlapped feedback:
  - Stimulus: feedback begins after row 2; the 16th feedback coincides with row 4 acceptance.
  - Required: direct STREAM -> IDLE transition; GNT drops at that edge; no FBWAIT cycle.
- Violations:
  - Stimulus: C_STROBE while luma is granted; CORE_FBSTROBE while idle.
  - Required: neither is forwarded; no C_FBSTROBE; PROTO_ERR=1 and stays set until RESET.
- Reset mid-block:
  - Stimulus: RESET after row 2.
  - Required: READY and FBSTROBE are 0 during RESET; all outputs are 0 after the edge; the next simultaneous L_REQ and C_REQ grants luma.
